// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

    localparam int unsigned PC_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_BRANCH,
        SEL_CALL,
        SEL_RET,
        SEL_RESET
    } next_pc_sel_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address LIFO: a full push overwrites the oldest entry, an empty pop only
// raises the sticky underflow flag.
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned IDX_W = clog2(DEPTH),
    localparam int unsigned CNT_W = IDX_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // ptr_q is the next free slot; when full it also points at the oldest entry
    logic [IDX_W-1:0] ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, empty, do_push;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign top_idx = ptr_q - IDX_W'(1);
    assign top_o   = mem_q[top_idx];

    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        do_push     = 1'b0;
        if (pop_i) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                ptr_d   = top_idx;
                count_d = count_q - CNT_W'(1);
            end
        end else if (push_i) begin
            do_push = 1'b1;
            ptr_d   = ptr_q + IDX_W'(1);
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: stall, branch/call/return redirects, fetch handshake and a
// return-address stack. All outputs are registered.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = PC_W_DEFAULT,
    parameter int unsigned PC_STEP      = 1,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned RAS_DEPTH    = 4,
    localparam int unsigned CNT_W       = clog2(RAS_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                call,
    input  logic                ret,
    input  logic                fetch_ready,
    output logic                fetch_valid,
    output logic [PC_WIDTH-1:0] pc_counter,
    output logic [CNT_W-1:0]    ras_count,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    localparam logic [PC_WIDTH-1:0] STEP   = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_VECTOR);

    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
    logic                fetch_valid_q, fetch_valid_d;
    logic                accept, ras_empty, ras_push;
    next_pc_sel_t        sel;

    assign pc_inc    = pc_q + STEP;
    assign accept    = fetch_valid_q & fetch_ready & ~stall;
    assign ras_empty = (ras_count == '0);
    // ret beats call, so a simultaneous call never pushes
    assign ras_push  = call & ~ret;

    always_comb begin
        sel = SEL_HOLD;
        if (reset) begin
            sel = SEL_RESET;
        end else if (ret) begin
            // an empty-stack return degrades to a plain increment
            sel = ras_empty ? SEL_INC : SEL_RET;
        end else if (call) begin
            sel = SEL_CALL;
        end else if (branch_taken) begin
            sel = SEL_BRANCH;
        end else if (accept) begin
            sel = SEL_INC;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        fetch_valid_d = 1'b1;
        case (sel)
            SEL_RESET: begin
                pc_d          = RST_PC;
                fetch_valid_d = 1'b0;
            end
            SEL_RET:    pc_d = ras_top;
            SEL_CALL:   pc_d = branch_target;
            SEL_BRANCH: pc_d = branch_target;
            SEL_INC:    pc_d = pc_inc;
            default: begin
                pc_d          = pc_q;
                fetch_valid_d = fetch_valid_q | ~stall;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RST_PC;
            fetch_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_return_stack (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (ras_push),
        .pop_i       (ret),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

    assign pc_counter  = pc_q;
    assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic, checked against
// a queue-based reference model.
module tb_pc_sequencer;

    localparam int W     = 8;
    localparam int STEPV = 1;
    localparam int RV    = 0;
    localparam int DEPTH = 4;
    localparam int MODV  = 1 << W;

    typedef struct {
        int pc;
        bit valid;
        int cnt;
        bit ovf;
        bit unf;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         branch_taken;
    logic [W-1:0] branch_target;
    logic         call;
    logic         ret;
    logic         fetch_ready;
    logic         fetch_valid;
    logic [W-1:0] pc_counter;
    logic [2:0]   ras_count;
    logic         ras_overflow;
    logic         ras_underflow;

    pc_sequencer #(
        .PC_WIDTH     (W),
        .PC_STEP      (STEPV),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .call          (call),
        .ret           (ret),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .pc_counter    (pc_counter),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    int   m_pc;
    bit   m_valid;
    bit   m_ovf;
    bit   m_unf;
    int   ras[$];
    exp_t exp_q[$];

    int vectors;
    int miscompares;

    task automatic model_update(input bit rst, input bit stl, input bit br, input int tgt,
                                input bit cl, input bit rt, input bit rdy);
        bit accept;
        accept = m_valid && rdy && !stl;
        if (rst) begin
            m_pc    = RV;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            ras.delete();
        end else begin
            if (rt) begin
                if (ras.size() > 0) begin
                    m_pc = ras.pop_back();
                end else begin
                    m_pc  = (m_pc + STEPV) % MODV;
                    m_unf = 1'b1;
                end
            end else if (cl) begin
                if (ras.size() == DEPTH) begin
                    void'(ras.pop_front());
                    m_ovf = 1'b1;
                end
                ras.push_back((m_pc + STEPV) % MODV);
                m_pc = tgt % MODV;
            end else if (br) begin
                m_pc = tgt % MODV;
            end else if (accept) begin
                m_pc = (m_pc + STEPV) % MODV;
            end
            if (rt || cl || br || !stl) m_valid = 1'b1;
        end
    endtask

    task automatic step(input bit rst, input bit stl, input bit br, input int tgt,
                        input bit cl, input bit rt, input bit rdy);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        stall         = stl;
        branch_taken  = br;
        branch_target = W'(tgt);
        call          = cl;
        ret           = rt;
        fetch_ready   = rdy;
        model_update(rst, stl, br, tgt, cl, rt, rdy);
        e.pc    = m_pc;
        e.valid = m_valid;
        e.cnt   = ras.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
    endtask

    // Hand-derived checkpoint, taken just after the edge that follows the last step
    task automatic spot(input string name, input int req_pc, input int req_cnt,
                        input bit req_ovf, input bit req_unf);
        @(posedge clk);
        #2;
        vectors++;
        if (int'(pc_counter) != req_pc || int'(ras_count) != req_cnt ||
            ras_overflow != req_ovf || ras_underflow != req_unf) begin
            miscompares++;
            $display("FAIL %s: got pc=%02h cnt=%0d ovf=%0b unf=%0b, want pc=%02h cnt=%0d ovf=%0b unf=%0b",
                     name, pc_counter, ras_count, ras_overflow, ras_underflow,
                     req_pc, req_cnt, req_ovf, req_unf);
        end
    endtask

    // Monitor: one expectation per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (int'(pc_counter) != e.pc || fetch_valid != e.valid ||
                    int'(ras_count) != e.cnt || ras_overflow != e.ovf ||
                    ras_underflow != e.unf) begin
                    miscompares++;
                    $display("FAIL scoreboard @%0t: got pc=%02h v=%0b cnt=%0d ovf=%0b unf=%0b, want pc=%02h v=%0b cnt=%0d ovf=%0b unf=%0b",
                             $time, pc_counter, fetch_valid, ras_count, ras_overflow,
                             ras_underflow, e.pc, e.valid, e.cnt, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        bit rst, stl, br, cl, rt, rdy;
        int tgt;

        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        call          = 1'b0;
        ret           = 1'b0;
        fetch_ready   = 1'b0;

        // Reset, then free run: valid rises first, pc counts 0..10
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        spot("reset", 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 0, 0, 1);
        spot("count_to_10", 10, 0, 0, 0);

        // Wrap through FF, then not-ready and stall holds
        step(0, 0, 1, 'hFD, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
        spot("wrap", 'h01, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        spot("not_ready_hold", 'h01, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 1);
        spot("stall_hold", 'h01, 0, 0, 0);

        // Branch under stall
        step(0, 0, 1, 'h05, 0, 0, 0);
        step(0, 1, 1, 'h40, 0, 0, 1);
        spot("branch_stall", 'h40, 0, 0, 0);

        // Call and return
        step(0, 0, 1, 'h10, 0, 0, 0);
        step(0, 0, 0, 'h80, 1, 0, 0);
        spot("call", 'h80, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        spot("ret", 'h11, 0, 0, 0);

        // Five nested calls overflow, four returns drain, fifth underflows
        step(0, 0, 1, 'h01, 0, 0, 0);
        step(0, 0, 0, 'h02, 1, 0, 0);
        step(0, 0, 0, 'h03, 1, 0, 0);
        step(0, 0, 0, 'h04, 1, 0, 0);
        step(0, 0, 0, 'h05, 1, 0, 0);
        step(0, 0, 0, 'h20, 1, 0, 0);
        spot("overflow", 'h20, 4, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        spot("drain", 'h03, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        spot("underflow", 'h04, 0, 1, 1);

        // Reset beats call+ret; then call+ret with two entries pops without pushing
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 'h77, 1, 1, 1);
        spot("reset_override", 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 'h30, 1, 0, 1);
        step(0, 0, 0, 'h50, 1, 0, 1);
        step(0, 0, 0, 'h70, 1, 1, 1);
        spot("call_ret_tie", 'h31, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        spot("no_push_on_tie", 'h01, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r   = $urandom_range(0, 99);
            rst = (r == 0);
            stl = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 7) == 0);
            cl  = ($urandom_range(0, 7) == 0);
            rt  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = $urandom_range(0, MODV - 1);
            step(rst, stl, br, tgt, cl, rt, rdy);
        end

        step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer; next generation of the free-running 8-bit pc_counter that currently drives Processor.
- Generates the fetch address with configurable width, step and reset vector.
- Adds a stall input, branch/jump redirect, a fetch valid/ready handshake, and a small return-address stack (RAS) for call/return.
- Sits between the control unit and instruction memory; its pc_counter output feeds Processor.pc_counter.

Parameters:
- PC_WIDTH, 8, width of the program counter in bits.
- PC_STEP, 1, increment applied per accepted fetch, modulo 2^PC_WIDTH.
- RESET_VECTOR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, at least 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and handshake state; ignored by redirects.
- branch_taken  input  1  load branch_target next cycle.
- branch_target  input  PC_WIDTH  target for branch and call.
- call  input  1  push return address, jump to branch_target.
- ret  input  1  pop RAS top into PC.
- fetch_ready  input  1  instruction memory accepts pc_counter.
- fetch_valid  output  1  pc_counter is a valid fetch request.
- pc_counter  output  PC_WIDTH  current fetch address.
- ras_count  output  clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_overflow  output  1  sticky flag: a push occurred while the RAS was full.
- ras_underflow  output  1  sticky flag: a pop occurred while the RAS was empty.

Behaviour:
- Reset, sampled at the clock edge while reset=1:
  - pc_counter=RESET_VECTOR, fetch_valid=0, ras_count=0, both flags=0.
  - RAS contents are don't-care.
  - Reset asserted mid-operation overrides every other input in that cycle.
- fetch_valid goes to 1 on the first edge after reset deasserts, and stays 1 thereafter.
- Accept condition: fetch_valid & fetch_ready & !stall.
- Next-PC priority, highest first:
  1. reset.
  2. ret: pc=RAS top; ras_count-1.
  3. call: push (pc_counter+PC_STEP) mod 2^PC_WIDTH; pc=branch_target.
  4. branch_taken: pc=branch_target.
  5. accept: pc=(pc+PC_STEP) mod 2^PC_WIDTH.
  6. Otherwise hold.
- Redirects (ret, call, branch_taken) take effect on the next edge regardless of stall or fetch_ready.
- Simultaneous call and ret: ret wins; no push occurs; ras_count decrements.
- Simultaneous call and branch_taken: call wins; push occurs and the jump goes to branch_target.
- The PC wraps without a flag, e.g. 8'hFF+1 = 8'h00.
- RAS is a circular buffer indexed by a top pointer.
  - Push when full: overwrite the oldest entry; ras_count stays at RAS_DEPTH; ras_overflow is set.
  - Pop when empty: PC instead increments by PC_STEP (treated as a plain accept, ignoring fetch_ready/stall); ras_count stays 0; ras_underflow is set.
- Both sticky flags clear only on reset.
- Latency: every PC change is visible one clock after the causing input is sampled. No combinational input-to-output paths.
- stall=1 with no redirect: pc_counter, fetch_valid and the RAS all hold.

Decomposition:
- Shared package pc_pkg holds:
  - localparam PC_W_DEFAULT=8;
  - enum next_pc_sel_t {SEL_HOLD, SEL_INC, SEL_BRANCH, SEL_CALL, SEL_RET, SEL_RESET};
  - function clog2.
- One natural sub-module: return_stack, a parametrised circular LIFO with push/pop, count and overflow/underflow outputs, instantiated once.
- Next-PC select logic and the handshake live in pc_sequencer.

Test Plan (PC_WIDTH=8, PC_STEP=1, RESET_VECTOR=0, RAS_DEPTH=4):
- Reset, then fetch_ready=1 for 10 cycles: fetch_valid=1 one cycle after reset drops; pc_counter steps 0,1,2…10.
- Run to pc=8'hFE with fetch_ready=1: pc goes FE, FF, 00 with no flag set. Then hold fetch_ready=0 for 3 cycles: pc stays 01. Set stall=1 with fetch_ready=1: pc also holds.
- At pc=5, branch_taken=1 with target 8'h40 while stall=1: next pc=8'h40.
- At pc=8'h10, call with target 8'h80: pc=8'h80 and ras_count=1. Later ret: pc=8'h11 and ras_count=0.
- Five calls from pc=1,2,3,4,5 without returns: ras_overflow=1, ras_count=4. Then four rets return 6,5,4,3. A fifth ret sets ras_underflow=1 and pc increments.
- Assert call, ret and reset together mid-run: pc=0, ras_count=0, both flags=0. Repeat without reset, with ras_count=2: ret wins, count goes to 1, and there is no push.
